// File: rtl/mips_control_pkg.sv
// Shared definitions for the multicycle MIPS control path: state encodings,
// opcodes, ALU control codes and the decoded control bundle.
package mips_control_pkg;

  localparam int unsigned STATE_W  = 4;
  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned WAIT_W   = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXECUTE   = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_HALT      = 4'd10
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'd0;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'd4;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'd35;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'd43;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] SRC_B_REG       = 2'b00;
  localparam logic [1:0] SRC_B_FOUR      = 2'b01;
  localparam logic [1:0] SRC_B_IMM       = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SHIFT = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       iord;
    logic       mem_ren;
    logic       mem_wen;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_wen;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       pc_source;
    logic       halted;
  } ctrl_t;

  // States that hold for MEM_WAIT+1 cycles while memory responds.
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Counts cycles spent in a memory-access state; done marks the final cycle.
module mem_wait_counter
  import mips_control_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic done
);

  logic [WAIT_W-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + WAIT_W'(1);
    end
  end

  assign done = (count == WAIT_W'(MEM_WAIT));

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for a multicycle MIPS datapath with a configurable
// number of memory wait cycles per access.
module multicycle_controller
  import mips_control_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  output logic                pc_en,
  output logic                iord,
  output logic                mem_ren,
  output logic                mem_wen,
  output logic                ir_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_wen,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic                pc_source,
  output logic                halted,
  output logic [STATE_W-1:0]  state
);

  state_t cur_state;
  state_t nxt_state;
  ctrl_t  ctrl;
  logic   in_mem;
  logic   wait_done;

  // Counter restarts at every memory-state entry by clearing outside those
  // states and on the final cycle of each access.
  assign in_mem = is_mem_state(cur_state);

  mem_wait_counter #(
    .MEM_WAIT (MEM_WAIT)
  ) u_wait (
    .clock  (clock),
    .reset  (reset),
    .clear  (!in_mem || wait_done),
    .enable (in_mem),
    .done   (wait_done)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cur_state <= S_IDLE;
    end else begin
      cur_state <= nxt_state;
    end
  end

  always_comb begin
    nxt_state = cur_state;
    ctrl      = '0;
    unique case (cur_state)
      S_IDLE: nxt_state = S_FETCH;
      S_FETCH: begin
        ctrl.mem_ren   = 1'b1;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.alu_op    = ALU_OP_ADD;
        ctrl.ir_write  = wait_done;
        ctrl.pc_write  = wait_done;
        if (wait_done) nxt_state = S_DECODE;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRC_B_IMM_SHIFT;
        ctrl.alu_op    = ALU_OP_ADD;
        if (opcode == OP_RTYPE)                        nxt_state = S_EXECUTE;
        else if (opcode == OP_LW || opcode == OP_SW)   nxt_state = S_MEM_ADDR;
        else if (opcode == OP_BEQ)                     nxt_state = S_BRANCH;
        else                                           nxt_state = S_HALT;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_OP_ADD;
        if (opcode == OP_LW)      nxt_state = S_MEM_READ;
        else if (opcode == OP_SW) nxt_state = S_MEM_WRITE;
        else                      nxt_state = S_HALT;
      end
      S_MEM_READ: begin
        ctrl.mem_ren = 1'b1;
        ctrl.iord    = 1'b1;
        if (wait_done) nxt_state = S_MEM_WB;
      end
      S_MEM_WB: begin
        ctrl.reg_wen    = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        nxt_state       = S_FETCH;
      end
      S_MEM_WRITE: begin
        ctrl.mem_wen = 1'b1;
        ctrl.iord    = 1'b1;
        if (wait_done) nxt_state = S_FETCH;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_REG;
        ctrl.alu_op    = ALU_OP_FUNCT;
        nxt_state      = S_ALU_WB;
      end
      S_ALU_WB: begin
        ctrl.reg_wen = 1'b1;
        ctrl.reg_dst = 1'b1;
        nxt_state    = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_REG;
        ctrl.alu_op    = ALU_OP_SUB;
        ctrl.pc_source = 1'b1;
        ctrl.branch    = 1'b1;
        nxt_state      = S_FETCH;
      end
      S_HALT: begin
        ctrl.halted = 1'b1;
        nxt_state   = S_HALT;
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  // zero only reaches pc_en through branch, which is set solely in BRANCH.
  assign pc_en      = ctrl.pc_write | (ctrl.branch & zero);
  assign iord       = ctrl.iord;
  assign mem_ren    = ctrl.mem_ren;
  assign mem_wen    = ctrl.mem_wen;
  assign ir_write   = ctrl.ir_write;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign reg_wen    = ctrl.reg_wen;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign pc_source  = ctrl.pc_source;
  assign halted     = ctrl.halted;
  assign state      = cur_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: three instances (MEM_WAIT 0, 2, 3) run
// random instruction streams against per-instance expected state sequences.
module tb_multicycle_controller;
  import mips_control_pkg::*;

  localparam int unsigned N = 3;
  localparam int MODE_RAND = 0;
  localparam int MODE_HALT = 1;
  localparam int MODE_LW   = 2;

  typedef struct {
    state_t s;
    bit     last;
  } step_t;

  logic           clock = 1'b0;
  logic           reset;
  logic [5:0]     opcode [N];
  logic [N-1:0]   zero;
  logic [N-1:0]   pc_en, iord, mem_ren, mem_wen, ir_write, reg_dst;
  logic [N-1:0]   mem_to_reg, reg_wen, alu_src_a, pc_source, halted;
  logic [1:0]     alu_src_b [N];
  logic [1:0]     alu_op [N];
  logic [3:0]     state [N];

  step_t q [N][$];
  int    mode;
  bit    halt_sent [N];
  int    instr_cnt [N];
  int    vectors = 0;
  int    misc = 0;

  always #5 clock = ~clock;

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    localparam int unsigned W = (gi == 0) ? 0 : ((gi == 1) ? 2 : 3);
    multicycle_controller #(.MEM_WAIT(W)) u_dut (
      .clock      (clock),
      .reset      (reset),
      .opcode     (opcode[gi]),
      .zero       (zero[gi]),
      .pc_en      (pc_en[gi]),
      .iord       (iord[gi]),
      .mem_ren    (mem_ren[gi]),
      .mem_wen    (mem_wen[gi]),
      .ir_write   (ir_write[gi]),
      .reg_dst    (reg_dst[gi]),
      .mem_to_reg (mem_to_reg[gi]),
      .reg_wen    (reg_wen[gi]),
      .alu_src_a  (alu_src_a[gi]),
      .alu_src_b  (alu_src_b[gi]),
      .alu_op     (alu_op[gi]),
      .pc_source  (pc_source[gi]),
      .halted     (halted[gi]),
      .state      (state[gi])
    );
  end

  function automatic int wait_of(input int g);
    return (g == 0) ? 0 : ((g == 1) ? 2 : 3);
  endfunction

  function automatic logic [18:0] obs_vec(input int g);
    return {state[g], pc_en[g], iord[g], mem_ren[g], mem_wen[g], ir_write[g],
            reg_dst[g], mem_to_reg[g], reg_wen[g], alu_src_a[g], alu_src_b[g],
            alu_op[g], pc_source[g], halted[g]};
  endfunction

  // Output table written straight from the per-state output list.
  function automatic logic [18:0] exp_vec(input state_t s, input bit last, input logic z);
    logic pe = 0, io = 0, mr = 0, mw = 0, ir = 0, rd = 0, m2r = 0, rw = 0, sa = 0, ps = 0, h = 0;
    logic [1:0] sb = 2'b00, op = 2'b00;
    case (s)
      S_FETCH:     begin mr = 1; sb = 2'b01; ir = last; pe = last; end
      S_DECODE:    sb = 2'b11;
      S_MEM_ADDR:  begin sa = 1; sb = 2'b10; end
      S_MEM_READ:  begin mr = 1; io = 1; end
      S_MEM_WB:    begin rw = 1; m2r = 1; end
      S_MEM_WRITE: begin mw = 1; io = 1; end
      S_EXECUTE:   begin sa = 1; op = 2'b10; end
      S_ALU_WB:    begin rw = 1; rd = 1; end
      S_BRANCH:    begin sa = 1; op = 2'b01; ps = 1; pe = z; end
      S_HALT:      h = 1;
      default:     ;
    endcase
    return {4'(s), pe, io, mr, mw, ir, rd, m2r, rw, sa, sb, op, ps, h};
  endfunction

  task automatic check(input int g, input string tag, input logic [18:0] exp);
    logic [18:0] obs;
    obs = obs_vec(g);
    vectors++;
    assert (obs === exp) else begin
      misc++;
      $error("FAIL %s dut%0d t=%0t observed=%h expected=%h", tag, g, $time, obs, exp);
    end
  endtask

  task automatic push(input int g, input state_t s, input bit last);
    step_t e;
    e.s = s;
    e.last = last;
    q[g].push_back(e);
  endtask

  // Expected cycle-by-cycle state walk of one instruction, FETCH onward.
  task automatic push_instr(input int g, input logic [5:0] op);
    int w;
    w = wait_of(g);
    opcode[g] = op;
    for (int i = 0; i <= w; i++) push(g, S_FETCH, i == w);
    push(g, S_DECODE, 0);
    case (op)
      6'd0:  begin push(g, S_EXECUTE, 0); push(g, S_ALU_WB, 0); end
      6'd35: begin
        push(g, S_MEM_ADDR, 0);
        for (int i = 0; i <= w; i++) push(g, S_MEM_READ, 0);
        push(g, S_MEM_WB, 0);
      end
      6'd43: begin
        push(g, S_MEM_ADDR, 0);
        for (int i = 0; i <= w; i++) push(g, S_MEM_WRITE, 0);
      end
      6'd4:  push(g, S_BRANCH, 0);
      default: push(g, S_HALT, 0);
    endcase
  endtask

  task automatic refill(input int g);
    logic [5:0] ops [4];
    ops[0] = 6'd0; ops[1] = 6'd35; ops[2] = 6'd4; ops[3] = 6'd43;
    if (mode == MODE_RAND) begin
      if (instr_cnt[g] < 4) push_instr(g, ops[instr_cnt[g]]);
      else push_instr(g, ops[$urandom_range(0, 3)]);
      instr_cnt[g]++;
    end else if (mode == MODE_HALT) begin
      if (!halt_sent[g]) begin
        push_instr(g, 6'd63);
        halt_sent[g] = 1;
      end else begin
        push(g, S_HALT, 0);
      end
    end else begin
      push_instr(g, 6'd35);
    end
  endtask

  task automatic body();
    step_t e;
    for (int g = 0; g < N; g++) if (q[g].size() == 0) refill(g);
    zero = N'($urandom);
    #1;
    for (int g = 0; g < N; g++) begin
      e = q[g].pop_front();
      check(g, "cycle", exp_vec(e.s, e.last, zero[g]));
    end
  endtask

  task automatic step();
    @(negedge clock);
    body();
  endtask

  task automatic release_reset(input int m);
    @(negedge clock);
    reset = 1'b1;
    mode = m;
    for (int g = 0; g < N; g++) begin
      q[g].delete();
      halt_sent[g] = 0;
      push(g, S_IDLE, 0);
    end
    body();
  endtask

  task automatic check_all_zero(input string tag);
    for (int g = 0; g < N; g++) check(g, tag, exp_vec(S_IDLE, 0, 1'b0));
  endtask

  initial begin
    reset = 1'b0;
    zero  = '1;
    for (int g = 0; g < N; g++) begin
      opcode[g] = 6'd0;
      instr_cnt[g] = 0;
    end
    mode = MODE_RAND;
    #12;
    check_all_zero("reset");

    release_reset(MODE_RAND);
    for (int i = 0; i < 400; i++) step();

    mode = MODE_HALT;
    for (int i = 0; i < 60; i++) step();

    @(negedge clock);
    #2 reset = 1'b0;
    #1 check_all_zero("halt_reset");

    release_reset(MODE_LW);
    // Instance with MEM_WAIT=3 is in its second MEM_READ cycle at step 8.
    for (int i = 0; i < 8; i++) step();
    #2 reset = 1'b0;
    #1 check_all_zero("mid_read_reset");

    release_reset(MODE_LW);
    for (int i = 0; i < 14; i++) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  end

endmodule
